argmax_frame_ctrl: RTL and testbench
====================================

// Module: argmax_frame_ctrl
// PURPOSE
//   Sequential classifier back-end. Accepts the NUM_CLASSES output-layer scores of one
//   inference frame as a valid/ready stream, one score per beat, class index 0 first.
//   Tracks the running maximum and its index, then presents the winning digit on a
//   valid/ready result port. Sits between the output neuron layer and the digit display/UART.
// PARAMETERS
//   NUM_CLASSES  10  scores per frame; must be >= 2
//   SCORE_W      8   score width; unsigned
//   IDX_W        4   class-index width; must satisfy 2**IDX_W >= NUM_CLASSES
// PORTS
//   clk          in   1        rising-edge clock; the only clock
//   rst_n        in   1        asynchronous, active-low reset
//   flush        in   1        synchronous abort: discard the partial frame or held result
//   s_valid      in   1        input score beat valid
//   s_ready      out  1        block accepts a beat when s_valid && s_ready
//   s_score      in   SCORE_W  score for class index = beat position in frame
//   s_last       in   1        marks the final beat of the frame
//   m_valid      out  1        result valid; held until accepted
//   m_ready      in   1        result consumer ready
//   m_digit      out  IDX_W    index of the maximum score
//   m_score      out  SCORE_W  the maximum score value
//   m_err        out  1        frame-length error for this result
//   frame_count  out  16       count of results accepted on m_*; wraps 0xFFFF->0
// BEHAVIOUR
//   - States: COLLECT (s_ready=1, m_valid=0) and RESULT (s_ready=0, m_valid=1).
//   - Reset (rst_n=0, async): state=COLLECT, beat count=0, m_valid=0, m_digit=0,
//     m_score=0, m_err=0, frame_count=0. s_ready=1 from the first clock after release.
//   - s_ready = (state==COLLECT) && !flush.
//   - On an accepted beat at position k (0-based): if k==0 or s_score > best_score,
//     then best_score<=s_score, best_idx<=k. Strict '>' means ties keep the lower index.
//   - Frame end: the beat with k==NUM_CLASSES-1, or any beat with s_last=1, whichever
//     comes first. On the next edge: state=RESULT, m_valid=1, m_digit/m_score = best
//     including the final beat, m_err = (s_last==0) || (k != NUM_CLASSES-1).
//     Early s_last gives a result over beats 0..k only.
//     Missing s_last at k==NUM_CLASSES-1 still ends the frame.
//   - Latency: m_valid rises 1 cycle after the final beat is accepted.
//     Throughput: with m_ready held high, one frame every NUM_CLASSES+1 cycles.
//   - RESULT: m_digit, m_score and m_err are stable while m_valid=1 && !m_ready.
//     On m_valid && m_ready: state=COLLECT, count=0, frame_count+=1, m_valid=0 next cycle.
//     The next frame's first beat is accepted no earlier than the cycle after the handshake.
//   - The beat counter never exceeds NUM_CLASSES-1. The counter and index are IDX_W wide
//     with no wrap inside a frame.
//   - flush=1: next edge sets state=COLLECT, count=0, m_valid=0. frame_count is unchanged.
//     A concurrent s_valid beat is not accepted (s_ready=0).
//     flush together with m_ready during RESULT: flush wins and frame_count is not incremented.
//   - rst_n asserted mid-frame or mid-result: everything clears immediately and the partial
//     frame is lost. No spurious m_valid on reset release.
//   - m_digit, m_score and m_err are registered outputs. No combinational path from s_* to m_*.
// TESTING
//   1. Scores 10,20,..,100 back-to-back, s_last on beat 9, m_ready=1 -> m_valid 1 cycle
//      after beat 9; digit=9, score=100, err=0; frame_count=1.
//   2. All ten scores 0x55 -> digit=0, score=0x55. Scores with 0xFF at beats 3 and 7,
//      others 0x01 -> digit=3.
//   3. Frame with max 0xC8 at beat 6, m_ready=0 for 5 cycles -> m_valid and outputs stable,
//      s_ready=0 throughout. m_ready=1 -> handshake; s_ready=1 next cycle.
//   4. s_last on beat 4 with scores 5,9,2,7,1 -> digit=1, score=9, err=1.
//      Ten beats without s_last -> result after beat 9, err=1.
//   5. Random s_valid gaps (~50% duty) over 1000 random frames -> digit matches a reference
//      lowest-index argmax model; frame_count=1000.
//   6. rst_n pulsed low after 5 beats, then a full frame -> correct result, frame_count=1.
//      flush after 3 beats -> no m_valid, next frame correct.
//      flush during RESULT with m_ready=1 -> m_valid drops, frame_count unchanged.

Source files
------------

// File: rtl/argmax_frame_ctrl_if.sv
// Stream bundle between the output neuron layer, the argmax back-end and the
// result consumer. The score stream (s_*) flows into the block; the result
// stream (m_*) flows out of it.
// master: the surrounding environment (score producer plus result consumer).
// slave:  the argmax block itself.
interface argmax_frame_ctrl_if #(
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned IDX_W   = 4
);

  // Score stream, one class score per beat
  logic               s_valid;
  logic               s_ready;
  logic [SCORE_W-1:0] s_score;
  logic               s_last;

  // Result stream, one winning digit per frame
  logic               m_valid;
  logic               m_ready;
  logic [IDX_W-1:0]   m_digit;
  logic [SCORE_W-1:0] m_score;
  logic               m_err;

  modport master (
    output s_valid, s_score, s_last, m_ready,
    input  s_ready, m_valid, m_digit, m_score, m_err
  );

  modport slave (
    input  s_valid, s_score, s_last, m_ready,
    output s_ready, m_valid, m_digit, m_score, m_err
  );

endinterface

// File: rtl/argmax_frame_ctrl.sv
// Sequential argmax back-end. Consumes NUM_CLASSES scores per frame, one per
// accepted beat, tracks the running maximum (ties keep the lower index) and
// presents the winning digit on a valid/ready result port.
// NUM_CLASSES must be >= 2 and 2**IDX_W >= NUM_CLASSES.
module argmax_frame_ctrl #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned IDX_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  argmax_frame_ctrl_if.slave        bus,
  output logic [15:0]               frame_count
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic {
    StCollect,
    StResult
  } state_e;

  state_e             state_q;
  // Holds s_ready low until the first clock after reset release
  logic               ready_en_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [SCORE_W-1:0] best_score_q;
  logic               m_valid_q;
  logic [IDX_W-1:0]   m_digit_q;
  logic [SCORE_W-1:0] m_score_q;
  logic               m_err_q;
  logic [15:0]        frame_count_q;

  logic               s_ready;
  logic               accept;
  logic               take_new;
  logic               frame_end;
  logic [IDX_W-1:0]   win_idx;
  logic [SCORE_W-1:0] win_score;

  // Beat acceptance and the running-best candidate including the current beat
  always_comb begin
    s_ready   = ready_en_q && (state_q == StCollect) && !flush;
    accept    = bus.s_valid && s_ready;
    // Beat 0 always seeds the maximum; later beats must be strictly larger
    take_new  = (cnt_q == '0) || (bus.s_score > best_score_q);
    win_idx   = take_new ? cnt_q : best_idx_q;
    win_score = take_new ? bus.s_score : best_score_q;
    frame_end = (cnt_q == LastIdx) || bus.s_last;
  end

  // Frame FSM: collect scores, then hold the result until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      ready_en_q    <= 1'b0;
      cnt_q         <= '0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      m_valid_q     <= 1'b0;
      m_digit_q     <= '0;
      m_score_q     <= '0;
      m_err_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        StCollect: begin
          if (flush) begin
            cnt_q <= '0;
          end else if (accept) begin
            best_idx_q   <= win_idx;
            best_score_q <= win_score;
            if (frame_end) begin
              state_q   <= StResult;
              m_valid_q <= 1'b1;
              m_digit_q <= win_idx;
              m_score_q <= win_score;
              // Clean frame only when s_last lands exactly on the last class
              m_err_q   <= !bus.s_last || (cnt_q != LastIdx);
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StResult: begin
          // flush beats a concurrent handshake and suppresses the count
          if (flush) begin
            state_q   <= StCollect;
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
          end else if (bus.m_ready) begin
            state_q       <= StCollect;
            m_valid_q     <= 1'b0;
            cnt_q         <= '0;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        default: begin
          state_q   <= StCollect;
          m_valid_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  // All result outputs come straight from flops
  always_comb begin
    bus.s_ready = s_ready;
    bus.m_valid = m_valid_q;
    bus.m_digit = m_digit_q;
    bus.m_score = m_score_q;
    bus.m_err   = m_err_q;
    frame_count = frame_count_q;
  end

endmodule

// File: tb/tb_argmax_frame_ctrl.sv
// Scoreboard bench for argmax_frame_ctrl: stimulus pushes the expected result
// of each frame, a monitor pops and compares on every result handshake.
module tb_argmax_frame_ctrl;

  localparam int N = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] frame_count;

  argmax_frame_ctrl_if #(.SCORE_W(8), .IDX_W(4)) bus ();

  argmax_frame_ctrl #(
    .NUM_CLASSES(N),
    .SCORE_W    (8),
    .IDX_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] digit;
    logic [7:0] score;
    logic       err;
  } res_t;

  res_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [7:0]  fb [N];
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every result handshake is checked against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready && !flush) begin
      res_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got digit %0d score 0x%0h, required no result (t=%0t)",
                 bus.m_digit, bus.m_score, $time);
      end else begin
        e = exp_q.pop_front();
        check("m_digit", 32'(bus.m_digit), 32'(e.digit));
        check("m_score", 32'(bus.m_score), 32'(e.score));
        check("m_err", 32'(bus.m_err), 32'(e.err));
        check("frame_count_at_hs", 32'(frame_count), 32'(exp_fc));
        exp_fc = exp_fc + 16'd1;
      end
    end
  end

  // Random consumer back-pressure for the long random run
  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [7:0] s, input logic e);
    exp_q.push_back('{digit: d, score: s, err: e});
  endtask

  // Presents one beat and returns once it has been accepted (posedge + 1)
  task automatic send_beat(input logic [7:0] score, input logic last);
    bit ok;
    int waited;
    bus.s_valid = 1'b1;
    bus.s_score = score;
    bus.s_last  = last;
    waited = 0;
    forever begin
      @(negedge clk);
      ok = bus.s_ready;
      tick();
      if (ok) break;
      waited++;
      if (waited > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: got no s_ready, required acceptance within 1000 cycles");
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit last_end, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) tick();
      send_beat(fb[i], last_end && (i == n - 1));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  best;
    logic [3:0]  bidx;
    logic [15:0] fc_start;

    bus.s_valid = 1'b0;
    bus.s_score = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_digit", 32'(bus.m_digit), 32'd0);
    check("rst_m_score", 32'(bus.m_score), 32'd0);
    check("rst_m_err", 32'(bus.m_err), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_s_ready_after_release", 32'(bus.s_ready), 32'd1);
    tick();

    // 1: ascending scores, winner on the last beat, 1-cycle latency
    bus.m_ready = 1'b1;
    for (int i = 0; i < N; i++) fb[i] = 8'((i + 1) * 10);
    push_exp(4'd9, 8'd100, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    @(negedge clk);
    check("latency_m_valid", 32'(bus.m_valid), 32'd1);
    tick();
    @(negedge clk);
    check("t1_frame_count", 32'(frame_count), 32'd1);
    check("t1_m_valid_low", 32'(bus.m_valid), 32'd0);
    tick();

    // 2: all ties -> index 0; two equal maxima -> lower index
    for (int i = 0; i < N; i++) fb[i] = 8'h55;
    push_exp(4'd0, 8'h55, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) fb[i] = 8'h01;
    fb[3] = 8'hFF;
    fb[7] = 8'hFF;
    push_exp(4'd3, 8'hFF, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    drain();

    // 3: result held under back-pressure
    bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) fb[i] = 8'(i * 16);
    fb[6] = 8'hC8;
    push_exp(4'd6, 8'hC8, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_m_valid", 32'(bus.m_valid), 32'd1);
      check("hold_m_digit", 32'(bus.m_digit), 32'd6);
      check("hold_m_score", 32'(bus.m_score), 32'hC8);
      check("hold_s_ready", 32'(bus.s_ready), 32'd0);
      tick();
    end
    bus.m_ready = 1'b1;
    tick();
    @(negedge clk);
    check("post_hs_s_ready", 32'(bus.s_ready), 32'd1);
    check("post_hs_m_valid", 32'(bus.m_valid), 32'd0);
    tick();

    // 4: early s_last and missing s_last
    fb[0] = 8'd5; fb[1] = 8'd9; fb[2] = 8'd2; fb[3] = 8'd7; fb[4] = 8'd1;
    push_exp(4'd1, 8'd9, 1'b1);
    send_frame(5, 1'b1, 1'b0);
    fb[0] = 8'd3; fb[1] = 8'd1; fb[2] = 8'd4; fb[3] = 8'd1; fb[4] = 8'd5;
    fb[5] = 8'd9; fb[6] = 8'd2; fb[7] = 8'd6; fb[8] = 8'd5; fb[9] = 8'd3;
    push_exp(4'd5, 8'd9, 1'b1);
    send_frame(N, 1'b0, 1'b0);
    drain();

    // 5: random frames with input gaps and random back-pressure
    fc_start   = frame_count;
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < N; i++)
        fb[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      best = fb[0];
      bidx = 4'd0;
      for (int i = 1; i < N; i++) begin
        if (fb[i] > best) begin
          best = fb[i];
          bidx = 4'(i);
        end
      end
      push_exp(bidx, best, 1'b0);
      send_frame(N, 1'b1, 1'b1);
    end
    rand_ready  = 1'b0;
    bus.m_ready = 1'b1;
    drain();
    check("random_frames_counted", 32'(frame_count - fc_start), 32'd1000);

    // 6a: reset mid-frame loses the partial frame
    for (int i = 0; i < 5; i++) send_beat(8'hF0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    tick();
    rst_n  = 1'b1;
    exp_fc = 16'd0;
    tick();
    tick();
    @(negedge clk);
    check("midrst_no_spurious_valid", 32'(bus.m_valid), 32'd0);
    tick();
    fb[0] = 8'd7; fb[1] = 8'd3; fb[2] = 8'h99; fb[3] = 8'd4; fb[4] = 8'h98;
    fb[5] = 8'd0; fb[6] = 8'h99; fb[7] = 8'd1; fb[8] = 8'd2; fb[9] = 8'd3;
    push_exp(4'd2, 8'h99, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    drain();
    check("midrst_frame_count_after", 32'(frame_count), 32'd1);

    // 6b: flush after 3 beats, concurrent beat refused
    for (int i = 0; i < 3; i++) send_beat(8'hF0, 1'b0);
    flush       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_score = 8'hFF;
    @(negedge clk);
    check("flush_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("flush_m_valid", 32'(bus.m_valid), 32'd0);
    tick();
    for (int i = 0; i < N; i++) fb[i] = 8'(i);
    fb[2] = 8'h80;
    push_exp(4'd2, 8'h80, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    drain();

    // 6c: flush during RESULT beats m_ready
    bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) fb[i] = 8'(N - i);
    send_frame(N, 1'b1, 1'b0);
    @(negedge clk);
    check("flushres_m_valid_before", 32'(bus.m_valid), 32'd1);
    tick();
    flush       = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flushres_m_valid_after", 32'(bus.m_valid), 32'd0);
    check("flushres_frame_count", 32'(frame_count), 32'(exp_fc));
    tick();
    fb[9] = 8'hFE;
    push_exp(4'd9, 8'hFE, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    drain();
    repeat (2) tick();
    check("final_frame_count", 32'(frame_count), 32'(exp_fc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
